audio_wr_arbiter: RTL and testbench

Shares the audio core's two write ports, the PSG attribute-RAM write port and the PCM FIFO write port, between two requesters: A (host bus interface) and B (autonomous audio sequencer/refill engine). Each requester issues single-byte writes through a valid/ready handshake. The arbiter grants one transfer per cycle, using round-robin with bounded bursts, and drives registered write strobes into `audio`. It also prevents PCM FIFO overflow by throttling on `pcm_fifo_full` and on any write still in flight.

---
 rtl/audio_wr_arbiter.sv | 89 ++++++++
 tb/tb_audio_wr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/audio_wr_arbiter.sv
// audio_wr_arbiter: shares the PSG attribute-RAM and PCM FIFO write ports between requesters A and B
// Ports: clk/rst (sync, active-high); a_*/b_* valid/ready single-byte write requests;
// pcm_fifo_full/pcm_fifo_reset throttle PCM grants; psg_* and pcm_fifo_* are registered write ports.
// Define AUDIO_ARB_FIXED_PRIO_EN for fixed A-over-B priority; otherwise round-robin with MAX_BURST bursts.
module audio_wr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic       a_is_pcm,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_is_pcm,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       pcm_fifo_full,
  input  logic       pcm_fifo_reset,
  output logic [4:0] psg_wraddr,
  output logic [7:0] psg_wrdata,
  output logic       psg_write,
  output logic [7:0] pcm_fifo_wrdata,
  output logic       pcm_fifo_write
);
  logic pcm_ok, elig_a, elig_b, gnt_a, gnt_b, gnt_psg, gnt_pcm;
  logic [4:0] addr;
  logic [7:0] data;
  // a PCM write still in flight blocks the next one, so the FIFO full flag is always current
  assign pcm_ok = !pcm_fifo_full && !pcm_fifo_write && !pcm_fifo_reset;
  assign elig_a = a_valid && (!a_is_pcm || pcm_ok);
  assign elig_b = b_valid && (!b_is_pcm || pcm_ok);
`ifdef AUDIO_ARB_FIXED_PRIO_EN
  assign gnt_a = elig_a;
  assign gnt_b = elig_b && !elig_a;
`else
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state;
  logic [3:0] burst_cnt;
  logic last_b, under, keep_a, keep_b;
  always_comb begin
    under  = burst_cnt < 4'(MAX_BURST);
    keep_a = elig_a && (under || !elig_b);
    keep_b = elig_b && (under || !elig_a);
    gnt_a  = state == OWN_A ? keep_a : state == OWN_B ? elig_a && !keep_b : elig_a && (!elig_b || last_b);
    gnt_b  = state == OWN_B ? keep_b : state == OWN_A ? elig_b && !keep_a : elig_b && (!elig_a || !last_b);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
    end else if (gnt_a || gnt_b) begin
      state     <= gnt_a ? OWN_A : OWN_B;
      burst_cnt <= (state == (gnt_a ? OWN_A : OWN_B)) ? burst_cnt + {3'b0, burst_cnt != 4'd15} : 4'd1;
      last_b    <= gnt_b;
    end else begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end
`endif
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign gnt_psg = gnt_a ? !a_is_pcm : gnt_b && !b_is_pcm;
  assign gnt_pcm = gnt_a ? a_is_pcm : gnt_b && b_is_pcm;
  assign addr    = gnt_a ? a_addr : b_addr;
  assign data    = gnt_a ? a_data : b_data;
  // reset also drops any strobe owed to a transfer accepted in the reset cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      psg_write       <= 1'b0;
      pcm_fifo_write  <= 1'b0;
      psg_wraddr      <= '0;
      psg_wrdata      <= '0;
      pcm_fifo_wrdata <= '0;
    end else begin
      psg_write      <= gnt_psg;
      pcm_fifo_write <= gnt_pcm;
      if (gnt_psg) begin
        psg_wraddr <= addr;
        psg_wrdata <= data;
      end
      if (gnt_pcm) pcm_fifo_wrdata <= data;
    end
  end
endmodule

// File: tb/tb_audio_wr_arbiter.sv
// tb_audio_wr_arbiter: directed and randomized checks of audio_wr_arbiter against a behavioural model
module tb_audio_wr_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst, a_valid, a_is_pcm, a_ready, b_valid, b_is_pcm, b_ready;
  logic [4:0] a_addr, b_addr, psg_wraddr;
  logic [7:0] a_data, b_data, psg_wrdata, pcm_fifo_wrdata;
  logic pcm_fifo_full, pcm_fifo_reset, psg_write, pcm_fifo_write;
  always #5 clk = ~clk;
  audio_wr_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_is_pcm(a_is_pcm), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_is_pcm(b_is_pcm), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .pcm_fifo_full(pcm_fifo_full), .pcm_fifo_reset(pcm_fifo_reset),
    .psg_wraddr(psg_wraddr), .psg_wrdata(psg_wrdata), .psg_write(psg_write),
    .pcm_fifo_wrdata(pcm_fifo_wrdata), .pcm_fifo_write(pcm_fifo_write)
  );
  int checks = 0, passed = 0;
  // model: who was granted last cycle (0 none, 1 A, 2 B), its run length, and who won most recently
  int prev, streak, last, gl;
  logic e_psg_w, e_pcm_w;
  logic [4:0] e_addr;
  logic [7:0] e_psg_d, e_pcm_d;
  logic ra, rb, o_psg_w, o_pcm_w;
  logic [7:0] o_pcm_d;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask
  task automatic model_reset();
    prev = 0; streak = 0; last = 2;
    e_psg_w = 0; e_pcm_w = 0; e_addr = 0; e_psg_d = 0; e_pcm_d = 0;
  endtask
  function automatic int model_grant();
    bit ok, ea, eb;
    ok = !pcm_fifo_full && !e_pcm_w && !pcm_fifo_reset;
    ea = a_valid && (!a_is_pcm || ok);
    eb = b_valid && (!b_is_pcm || ok);
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    return ea ? 1 : eb ? 2 : 0;
`else
    if (prev == 1) return (ea && (streak < MB || !eb)) ? 1 : eb ? 2 : 0;
    if (prev == 2) return (eb && (streak < MB || !ea)) ? 2 : ea ? 1 : 0;
    if (ea && eb) return last == 1 ? 2 : 1;
    return ea ? 1 : eb ? 2 : 0;
`endif
  endfunction
  task automatic commit(input int g);
    bit pcm;
    pcm = g == 1 ? a_is_pcm : b_is_pcm;
    e_psg_w = g != 0 && !pcm;
    e_pcm_w = g != 0 && pcm;
    if (e_psg_w) begin
      e_addr  = g == 1 ? a_addr : b_addr;
      e_psg_d = g == 1 ? a_data : b_data;
    end
    if (e_pcm_w) e_pcm_d = g == 1 ? a_data : b_data;
    streak = g == 0 ? 0 : g == prev ? streak + 1 : 1;
    prev = g;
    if (g != 0) last = g;
  endtask
  task automatic step();
    int g;
    #1;
    g = model_grant();
    ra = a_ready; rb = b_ready; o_psg_w = psg_write; o_pcm_w = pcm_fifo_write; o_pcm_d = pcm_fifo_wrdata;
    chk("a_ready", a_ready, g == 1);
    chk("b_ready", b_ready, g == 2);
    chk("psg_write", psg_write, e_psg_w);
    chk("pcm_fifo_write", pcm_fifo_write, e_pcm_w);
    chk("psg_wraddr", psg_wraddr, e_addr);
    chk("psg_wrdata", psg_wrdata, e_psg_d);
    chk("pcm_fifo_wrdata", pcm_fifo_wrdata, e_pcm_d);
    gl = g;
    @(posedge clk);
    if (rst) model_reset();
    else commit(g);
    @(negedge clk);
  endtask
  initial begin
    string exp_seq;
    int outs, next, last_pulse, cyc;
    rst = 1; a_valid = 0; a_is_pcm = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_is_pcm = 0; b_addr = 0; b_data = 0;
    pcm_fifo_full = 0; pcm_fifo_reset = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step(); step();
    rst = 0;
    a_valid = 1; a_addr = 5'h0A; a_data = 8'h3C;
    step();
    chk("t1_a_ready", ra, 1);
    a_valid = 0;
    step();
    chk("t1_psg_write", o_psg_w, 1);
    chk("t1_psg_wraddr", psg_wraddr, 5'h0A);
    chk("t1_psg_wrdata", psg_wrdata, 8'h3C);
    chk("t1_pcm_write", o_pcm_w, 0);
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    exp_seq = "AAAAAAAAAA";
`else
    exp_seq = "BBBBAAAABB";
`endif
    a_valid = 1; b_valid = 1; b_is_pcm = 0;
    for (int i = 0; i < 10; i++) begin
      a_addr = 5'($urandom); a_data = 8'($urandom); b_addr = 5'($urandom); b_data = 8'($urandom);
      step();
      chk("t2_grant_seq", ra ? 8'h41 : rb ? 8'h42 : 8'h2D, exp_seq[i]);
    end
    a_valid = 0;
    step();
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    chk("t6_b_same_cycle", rb, 1);
`endif
    b_valid = 0;
    step();
    b_is_pcm = 1; next = 1; outs = 0; last_pulse = -10; cyc = 0;
    while (outs < 8 && cyc < 40) begin
      b_valid = next <= 8; b_data = 8'(next);
      step();
      if (rb) next++;
      chk("t3_ready_vs_pcm_write", rb && o_pcm_w, 0);
      if (o_pcm_w) begin
        outs++;
        chk("t3_pcm_order", o_pcm_d, outs);
        if (outs > 1) chk("t3_pcm_spacing", cyc - last_pulse, 2);
        last_pulse = cyc;
      end
      cyc++;
    end
    chk("t3_pcm_count", outs, 8);
    b_valid = 0;
    step();
    pcm_fifo_full = 1; a_valid = 1; a_is_pcm = 0; b_valid = 1; b_is_pcm = 1; b_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      a_addr = 5'($urandom); a_data = 8'($urandom);
      step();
      chk("t4_a_granted", ra, 1);
      chk("t4_b_held", rb, 0);
    end
    pcm_fifo_full = 0; a_valid = 0;
    step();
    chk("t4_b_after_full", rb, 1);
    b_valid = 0;
    step();
    pcm_fifo_reset = 1; b_valid = 1; b_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_pcm_in_reset", rb, 0);
    end
    pcm_fifo_reset = 0;
    step();
    chk("t5_resume", rb, 1);
    b_valid = 0;
    step();
    for (int i = 0; i < 3000; i++) begin
      if (gl == 1 || rst) a_valid = 0;
      if (gl == 2 || rst) b_valid = 0;
      if (!a_valid && $urandom_range(3) != 0) begin
        a_valid = 1; a_is_pcm = $urandom_range(2) == 0; a_addr = 5'($urandom); a_data = 8'($urandom);
      end
      if (!b_valid && $urandom_range(3) != 0) begin
        b_valid = 1; b_is_pcm = $urandom_range(2) == 0; b_addr = 5'($urandom); b_data = 8'($urandom);
      end
      pcm_fifo_full = $urandom_range(4) == 0;
      pcm_fifo_reset = $urandom_range(19) == 0;
      rst = $urandom_range(149) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
